// File: rtl/sat_if.sv
// Sample bus for the signed saturator: the producer-side sample/qualifier
// and the registered saturated result with its overflow flags.
interface sat_if #(
  parameter int isz = 17,
  parameter int osz = 16
);
  // ena qualifies in for one edge; valid pulses one cycle later for every
  // accepted sample. There is no backpressure, so a new sample may arrive every cycle.
  logic                  ena;
  logic signed [isz-1:0] in;
  logic                  sticky_clr;
  logic signed [osz-1:0] out;
  logic                  valid;
  logic                  ovf_pos;
  logic                  ovf_neg;
  logic                  ovf_sticky;

  modport master (
    output ena, in, sticky_clr,
    input  out, valid, ovf_pos, ovf_neg, ovf_sticky
  );

  modport slave (
    input  ena, in, sticky_clr,
    output out, valid, ovf_pos, ovf_neg, ovf_sticky
  );
endinterface

// File: rtl/sat.sv
// Registered signed saturator: clamps an isz-bit two's-complement sample to
// osz bits, with per-sample overflow flags and a sticky overflow status.
module sat #(
  parameter int isz = 17,
  parameter int osz = 16
) (
  input  logic  clk,
  input  logic  reset,
  sat_if.slave  s
);
  generate
    if (isz < osz) begin : g_bad_width
      $error("sat: isz (%0d) must be >= osz (%0d)", isz, osz);
    end
  endgenerate

  localparam logic [osz-1:0] MAX_VAL = {1'b0, {(osz-1){1'b1}}};
  localparam logic [osz-1:0] MIN_VAL = {1'b1, {(osz-1){1'b0}}};

  logic [isz-osz:0] top_bits;
  logic             fits;
  logic             clamp_pos;
  logic             clamp_neg;

  logic [osz-1:0] out_q, out_d;
  logic           valid_q, valid_d;
  logic           pos_q, pos_d;
  logic           neg_q, neg_d;
  logic           sticky_q, sticky_d;

  // The value fits when every bit from the sign down to bit osz-1 agrees.
  assign top_bits  = s.in[isz-1:osz-1];
  assign fits      = (&top_bits) | ~(|top_bits);
  assign clamp_pos = s.ena & ~fits & ~s.in[isz-1];
  assign clamp_neg = s.ena & ~fits &  s.in[isz-1];

  always_comb begin
    out_d    = out_q;
    valid_d  = s.ena;
    pos_d    = clamp_pos;
    neg_d    = clamp_neg;
    sticky_d = sticky_q;
    if (s.ena) begin
      if (clamp_pos)      out_d = MAX_VAL;
      else if (clamp_neg) out_d = MIN_VAL;
      else                out_d = s.in[osz-1:0];
    end
    // A clamp on the same edge as a clear keeps the flag set.
    if (clamp_pos || clamp_neg) sticky_d = 1'b1;
    else if (s.sticky_clr)      sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q    <= '0;
      valid_q  <= 1'b0;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      valid_q  <= valid_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      sticky_q <= sticky_d;
    end
  end

  assign s.out        = out_q;
  assign s.valid      = valid_q;
  assign s.ovf_pos    = pos_q;
  assign s.ovf_neg    = neg_q;
  assign s.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_sat.sv
// Directed bench for sat (isz=17, osz=16): a vector table applied one edge at
// a time plus hand-written reset sequences.
module tb_sat;
  logic clk;
  logic reset;

  sat_if #(.isz(17), .osz(16)) bus ();

  sat #(.isz(17), .osz(16)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ena;
    logic [16:0] din;
    logic        clr;
    logic [15:0] e_out;
    logic        e_valid;
    logic        e_pos;
    logic        e_neg;
    logic        e_sticky;
  } vec_t;

  vec_t vecs[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  function automatic void add(string nm, logic en, logic [16:0] d, logic c,
                              logic [15:0] eo, logic ev, logic ep, logic eneg,
                              logic es);
    vec_t v;
    v.name = nm; v.ena = en; v.din = d; v.clr = c;
    v.e_out = eo; v.e_valid = ev; v.e_pos = ep; v.e_neg = eneg; v.e_sticky = es;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic [15:0] eo, logic ev, logic ep,
                       logic eneg, logic es);
    logic [19:0] act, exp;
    act = {bus.out, bus.valid, bus.ovf_pos, bus.ovf_neg, bus.ovf_sticky};
    exp = {eo, ev, ep, eneg, es};
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got out=%h valid=%b pos=%b neg=%b sticky=%b, expected out=%h valid=%b pos=%b neg=%b sticky=%b",
               nm, act[19:4], act[3], act[2], act[1], act[0],
               exp[19:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(logic en, logic [16:0] d, logic c);
    bus.ena        = en;
    bus.in         = d;
    bus.sticky_clr = c;
  endtask

  initial begin
    //    name              ena  in         clr  out      v  p  n  s
    add("pass_max",          1, 17'h07FFF, 0, 16'h7FFF, 1, 0, 0, 0);
    add("pass_min",          1, 17'h18000, 0, 16'h8000, 1, 0, 0, 0);
    add("pass_neg1",         1, 17'h1FFFF, 0, 16'hFFFF, 1, 0, 0, 0);
    add("clamp_max_p1",      1, 17'h08000, 0, 16'h7FFF, 1, 1, 0, 1);
    add("clamp_pos_full",    1, 17'h0FFFF, 0, 16'h7FFF, 1, 1, 0, 1);
    add("clr_idle",          0, 17'h00000, 1, 16'h7FFF, 0, 0, 0, 0);
    add("clamp_min_m1",      1, 17'h17FFF, 0, 16'h8000, 1, 0, 1, 1);
    add("clamp_neg_full",    1, 17'h10000, 0, 16'h8000, 1, 0, 1, 1);
    add("clr_idle2",         0, 17'h00123, 1, 16'h8000, 0, 0, 0, 0);
    add("stream_5",          1, 17'h00005, 0, 16'h0005, 1, 0, 0, 0);
    add("stream_70000",      1, 17'h11170, 0, 16'h8000, 1, 0, 1, 1);
    add("stream_m3",         1, 17'h1FFFD, 0, 16'hFFFD, 1, 0, 0, 1);
    add("stream_0",          1, 17'h00000, 0, 16'h0000, 1, 0, 0, 1);
    add("hold_after",        0, 17'h0ABCD, 0, 16'h0000, 0, 0, 0, 1);
    add("hold_again",        0, 17'h12345, 0, 16'h0000, 0, 0, 0, 1);
    add("clr_before_set",    0, 17'h00000, 1, 16'h0000, 0, 0, 0, 0);
    add("clr_with_clamp",    1, 17'h09C40, 1, 16'h7FFF, 1, 1, 0, 1);
    add("clr_with_pass",     1, 17'h00010, 1, 16'h0010, 1, 0, 0, 0);

    drive(0, '0, 0);
    reset = 1'b0;
    #1;
    check("reset_state", 16'h0000, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].ena, vecs[i].din, vecs[i].clr);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].e_out, vecs[i].e_valid, vecs[i].e_pos,
            vecs[i].e_neg, vecs[i].e_sticky);
    end

    // Async reset mid-stream with a pending clamp and sticky set.
    @(negedge clk);
    drive(1, 17'h0C000, 0);
    @(posedge clk);
    #1;
    check("pre_reset_clamp", 16'h7FFF, 1, 1, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 16'h0000, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("held_in_reset", 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 17'h00007, 0);
    @(posedge clk);
    #1;
    check("first_after_reset", 16'h0007, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, '0, 0);
    @(posedge clk);
    #1;
    check("idle_after_reset", 16'h0007, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/sat.md
Name: sat

Overview:
- Registered signed saturator: clamps a wide two's-complement sample into a narrower output word.
- Sits at the output of accumulator/filter datapaths, e.g. an FIR decimator dump stage with `isz = agrw + osz - 2`.
- Sample-accurate overflow flags are provided per sample.
- A sticky overflow status is provided for software/monitoring.

Parameters:
- isz, 17, input word width in bits (signed); must be >= osz.
- osz, 16, output word width in bits (signed).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- ena  input  1  input sample qualifier; `in` is sampled when high.
- in  input  isz  signed input sample.
- sticky_clr  input  1  synchronous clear of the sticky overflow flag.
- out  output  osz  signed saturated sample, registered.
- valid  output  1  high for exactly one cycle per accepted sample.
- ovf_pos  output  1  high with `valid` when the sample was clamped to the positive maximum.
- ovf_neg  output  1  high with `valid` when the sample was clamped to the negative minimum.
- ovf_sticky  output  1  set by any clamp; held until `sticky_clr`.

Behaviour:
- Reset (reset = 0, asynchronous, effective immediately regardless of clk): out = 0, valid = 0, ovf_pos = 0, ovf_neg = 0, ovf_sticky = 0.
- Deassertion of reset is sampled synchronously; the first accept can occur on the first rising edge after release.
- Latency: `ena` high at edge N → out, valid, ovf_pos and ovf_neg update at edge N. They are visible in cycle N+1, one register stage.
- ena = 0 at an edge: valid and ovf_pos/ovf_neg go to 0; out holds its previous value.
- Clamp rule (combinational on `in`, then registered). Let MAX = 2^(osz-1) - 1 and MIN = -2^(osz-1).
  - Inspect the top isz-osz+1 bits of `in` (bits isz-1 down to osz-1).
  - All equal: the value fits; out = in[osz-1:0], no flag.
  - Sign bit in[isz-1] = 0 and any other inspected bit is 1: out = MAX, ovf_pos = 1.
  - Sign bit = 1 and any other inspected bit is 0: out = MIN, ovf_neg = 1.
- ovf_pos and ovf_neg are mutually exclusive; never both high.
- isz == osz: pure registered pass-through; overflow flags are never set.
- isz < osz: illegal; elaboration must fail via a parameter check.
- Boundaries: in = MAX and in = MIN pass unflagged. in = MAX+1 clamps to MAX; in = MIN-1 clamps to MIN. Full-scale extremes of `in` clamp correctly.
- Sticky flag: set at any edge where a clamp is registered (ovf_pos or ovf_neg being loaded as 1).
- sticky_clr = 1 at an edge clears ovf_sticky, unless a clamp is registered at the same edge; in that case set wins and the flag stays 1.
- sticky_clr has no effect on out, valid, or the per-sample flags.
- Reset mid-stream discards any in-flight sample; no valid pulse is produced for a sample accepted at the edge coincident with reset assertion.
- Back-to-back ena (every cycle) is supported at full throughput; no backpressure exists.

Test Plan (defaults isz = 17, osz = 16):
- In-range pass-through:
  - ena pulse with in = 32767 → next cycle out = 0x7FFF, valid = 1, ovf_pos = 0, ovf_neg = 0.
  - ena pulse with in = -32768 → out = 0x8000, no flags.
- Positive clamp: in = 32768 (0x08000) and in = 65535 (0x0FFFF) → out = 0x7FFF, ovf_pos = 1, ovf_sticky = 1.
- Negative clamp: in = -32769 (0x17FFF) and in = -65536 (0x10000) → out = 0x8000, ovf_neg = 1, ovf_sticky = 1.
- Streaming and hold:
  - ena high for 4 consecutive cycles with in = 5, 70000-wrapped, -3, 0 → 4 consecutive valid pulses with correct outputs, each one cycle late.
  - Afterwards ena = 0 → valid = 0 and out holds 0.
- Sticky control:
  - Set sticky, then pulse sticky_clr with ena = 0 → ovf_sticky = 0.
  - Pulse sticky_clr in the same cycle as an ena with in = 40000 → ovf_sticky remains 1.
- Async reset: assert reset = 0 between clock edges while streaming → all outputs 0 immediately. After release, the first ena produces a valid result one cycle later.
